// File: rtl/mult_div.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit feeding the HI/LO register pair.
// Define MULT_DIV_FAST_MUL_EN to replace the 32-step multiply with a single-cycle multiplier.
module mult_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        write_en,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic            is_div;
  logic            neg_res;
  logic            neg_rem;
  logic [W-1:0]    opnd;
  logic [W-1:0]    acc_hi;
  logic [W-1:0]    acc_lo;
  logic [CW-1:0]   cnt;

  // Operand sign extraction and magnitudes (unsigned ops never negate)
  logic            sign_a, sign_b;
  logic [W-1:0]    abs_a, abs_b;

  assign sign_a = ~op[0] & src_a[W-1];
  assign sign_b = ~op[0] & src_b[W-1];
  assign abs_a  = sign_a ? W'(-src_a) : src_a;
  assign abs_b  = sign_b ? W'(-src_b) : src_b;

  // Shift-add multiply step: multiplicand in opnd, multiplier shifts out of acc_lo
  logic [W:0]      mul_sum;
  logic [W-1:0]    mul_hi, mul_lo;

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : (W+1)'(0));
  assign mul_hi  = mul_sum[W:1];
  assign mul_lo  = {mul_sum[0], acc_lo[W-1:1]};

  // Restoring divide step: remainder in acc_hi, dividend/quotient in acc_lo
  logic [W:0]      div_sh, div_diff;
  logic            div_ge;
  logic [W-1:0]    div_hi, div_lo;

  assign div_sh   = {acc_hi, acc_lo[W-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign div_ge   = ~div_diff[W];
  assign div_hi   = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
  assign div_lo   = {acc_lo[W-2:0], div_ge};

  logic [W-1:0]    step_hi, step_lo;

  assign step_hi = is_div ? div_hi : mul_hi;
  assign step_lo = is_div ? div_lo : mul_lo;

  // Sign fixup applied to the final step's result on the way into DONE
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    fin_hi, fin_lo;

  assign prod_fix = neg_res ? (2*W)'(-{step_hi, step_lo}) : {step_hi, step_lo};
  assign fin_lo   = is_div ? (neg_res ? W'(-step_lo) : step_lo) : prod_fix[W-1:0];
  assign fin_hi   = is_div ? (neg_rem ? W'(-step_hi) : step_hi) : prod_fix[2*W-1:W];

`ifdef MULT_DIV_FAST_MUL_EN
  logic [2*W-1:0]  fast_prod, fast_fix;

  assign fast_prod = {{W{1'b0}}, abs_a} * {{W{1'b0}}, abs_b};
  assign fast_fix  = (sign_a ^ sign_b) ? (2*W)'(-fast_prod) : fast_prod;
`endif

  assign busy     = ~rst & (((state == IDLE) & start & ~flush) | (state == MUL) | (state == DIV));
  assign write_en = ~rst & (state == DONE) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            is_div  <= op[1];
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            cnt     <= '0;
            acc_hi  <= '0;
            if (op[1]) begin
              if (src_b == '0) begin
                hi_o  <= src_a;
                lo_o  <= '1;
                state <= DONE;
              end else begin
                opnd   <= abs_b;
                acc_lo <= abs_a;
                state  <= DIV;
              end
            end else begin
`ifdef MULT_DIV_FAST_MUL_EN
              {hi_o, lo_o} <= fast_fix;
              state        <= DONE;
`else
              opnd   <= abs_a;
              acc_lo <= abs_b;
              state  <= MUL;
`endif
            end
          end
        end
        MUL, DIV: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(W-1)) begin
              hi_o  <= fin_hi;
              lo_o  <= fin_lo;
              state <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Directed self-checking bench for mult_div; checks results, latency, busy, flush and reset.
module tb_mult_div;

`ifdef MULT_DIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        write_en;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;

  mult_div dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .write_en (write_en),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Enters cycle 0 of a new operation
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
  endtask

  // Counts cycles from the current cycle (0) until write_en; lat = -1 on timeout
  task automatic wait_done(input string tag, output int lat, output int bcyc);
    int cyc;
    cyc  = 0;
    bcyc = 0;
    lat  = -1;
    repeat (40) begin
      @(negedge clk);
      if (write_en === 1'b1) begin
        lat = cyc;
        check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        break;
      end
      if (busy === 1'b1) bcyc++;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
  endtask

  task automatic finish_checks(input string tag, input int lat, input int bcyc, input int elat,
                               input logic [31:0] ehi, input logic [31:0] elo);
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_busy_cycles"}, 64'(bcyc), 64'(elat));
    check({tag, "_hi"}, 64'(hi_o), 64'(ehi));
    check({tag, "_lo"}, 64'(lo_o), 64'(elo));
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_pulse_end"}, 64'(write_en), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int elat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int lat, bcyc;
    start_op(o, a, b);
    wait_done(tag, lat, bcyc);
    finish_checks(tag, lat, bcyc, elat, ehi, elo);
  endtask

  initial begin
    int lat, bcyc, we_seen;
    rst   = 1'b1;
    start = 1'b1;
    op    = 2'b11;
    src_a = 32'd100;
    src_b = 32'd7;
    flush = 1'b0;

    // Reset state, busy forced low while reset held even with start
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_write_en", 64'(write_en), 64'd0);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("mult_neg3x5", 2'b00, 32'hFFFFFFFD, 32'd5, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, MUL_LAT, 32'h40000000, 32'h00000000);
    run_op("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFFFFFE, DIV_LAT, 32'h00000001, 32'hFFFFFFFD);
    run_op("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h00000000, 32'h80000000);
    run_op("divu_by0", 2'b11, 32'h12345678, 32'd0, 1, 32'h12345678, 32'hFFFFFFFF);
    run_op("div_by0", 2'b10, 32'hFFFFFFF9, 32'd0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF);

    // Flush and start together: operation must not be accepted
    @(posedge clk);
    #1;
    start = 1'b1;
    flush = 1'b1;
    op    = 2'b11;
    src_a = 32'd100;
    src_b = 32'd7;
    @(negedge clk);
    check("flush_start_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_start_idle", 64'(busy), 64'd0);

    // DIVU 100/7 flushed in cycle 10, restarted in cycle 11
    start_op(2'b11, 32'd100, 32'd7);
    we_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (write_en === 1'b1) we_seen++;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_c10", 64'(busy), 64'd1);
    check("flush_we_c10", 64'(write_en), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_we_before", 64'(we_seen), 64'd0);
    check("flush_busy_c11", 64'(busy), 64'd0);
    check("flush_we_c11", 64'(write_en), 64'd0);
    check("flush_hold_hi", 64'(hi_o), 64'hFFFFFFF9);
    check("flush_hold_lo", 64'(lo_o), 64'hFFFFFFFF);
    start = 1'b1;
    wait_done("divu_after_flush", lat, bcyc);
    finish_checks("divu_after_flush", lat, bcyc, DIV_LAT, 32'd2, 32'd14);

    // Reset in cycle 20 of a DIV
    start_op(2'b10, 32'd1000, 32'd3);
    repeat (20) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_we", 64'(write_en), 64'd0);
    check("midrst_hi", 64'(hi_o), 64'd0);
    check("midrst_lo", 64'(lo_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    we_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (write_en === 1'b1 || busy === 1'b1) we_seen++;
    end
    check("midrst_quiet", 64'(we_seen), 64'd0);
    run_op("divu_after_rst", 2'b11, 32'd1000, 32'd3, DIV_LAT, 32'd1, 32'd333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div.md
# mult_div

Multi-cycle multiply/divide unit for MIPS MULT, MULTU, DIV and DIVU. It sits in the execute stage directly upstream of the HI/LO register pair. It accepts one operation at a time from EX and stalls the pipeline while iterating. On completion it drives a one-cycle write pulse together with the 64-bit result, ready for HI/LO to capture on the next edge.

## Interface
- No parameters; operand and result width fixed at 32 bits.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, asynchronous, active-high.
- `start`  in  1  — operation request from EX; sampled only in IDLE.
- `op`  in  2  — operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  32  — rs operand (multiplicand / dividend).
- `src_b`  in  32  — rt operand (multiplier / divisor).
- `flush`  in  1  — synchronous cancel of any in-flight operation.
- `busy`  out  1  — stall request to the pipeline.
- `write_en`  out  1  — one-cycle result-valid pulse to HI/LO.
- `hi_o`  out  32  — high product word / remainder.
- `lo_o`  out  32  — low product word / quotient.

## Operation
- FSM states:
  - IDLE: no operation in flight; `start=1` (and `flush=0`) latches `op`, operand magnitudes and sign flags.
    - DIV/DIVU with `src_b==0` → DONE.
    - Multiply with the fast multiplier (see Configuration) → DONE.
    - Other multiplies → MUL.
    - Other divides → DIV.
  - MUL: one shift-add step per cycle; 32 steps, then → DONE.
  - DIV: restoring division on magnitudes; one quotient bit per cycle; 32 steps, then → DONE.
  - DONE: lasts one cycle; → IDLE.
- Signed ops (MULT/DIV) operate on magnitudes and apply sign fixup when entering DONE:
  - Product is negated if operand signs differ.
  - Quotient is negated if operand signs differ; remainder takes the dividend's sign.
- Result mapping:
  - Multiply: `hi_o` = product[63:32], `lo_o` = product[31:0].
  - Divide: `lo_o` = quotient, `hi_o` = remainder.
- Divide by zero (both signed and unsigned): `hi_o = src_a`, `lo_o = 32'hFFFFFFFF`; no iteration.
- DIV 0x80000000 / 0xFFFFFFFF: `lo_o = 32'h80000000`, `hi_o = 0` (wraps; no trap).
- `hi_o`/`lo_o` are registered. They update only on entry to DONE and otherwise hold the last result.
- `write_en` = (state==DONE) && !flush.
- `busy` = (state==IDLE && start && !flush) || state==MUL || state==DIV. It is 0 in DONE, so the stalled instruction advances in the write cycle.
- `start` outside IDLE is ignored (EX is held by `busy`).

## Timing
- Cycle numbering: cycle 0 is the cycle in which `start` is high; edge E0 ends it.
- Iterative MUL/DIV: E0 loads operands, E1..E32 iterate, cycle 33 is DONE → `write_en=1`. Latency: 33 cycles from start to `write_en`.
- Divide by zero, and fast multiply: DONE in cycle 1.
- HI/LO captures the result at the edge ending the DONE cycle. The earliest next `start` is accepted in the cycle after DONE.
- `flush` sampled at any edge in MUL/DIV/DONE → IDLE. No `write_en` is produced and `hi_o`/`lo_o` are unchanged. `flush` during DONE masks `write_en` combinationally.
- `flush` and `start` high in the same cycle: `flush` wins and the operation is not accepted.
- `rst` asserted at any time, including mid-iteration:
  - Immediately: state IDLE, `hi_o=0`, `lo_o=0`, `write_en=0`, `busy=0`, iteration counter 0.
  - While `rst` is held, `busy` is forced to 0.

## Configuration
- `MULT_DIV_FAST_MUL_EN` defined: MULT/MULTU use a single-cycle 32x32 multiplier. Result lands at E0, DONE in cycle 1, and MUL state is unused.
- Undefined: multiplies use the 32-step iterative MUL path with 33-cycle latency, the same as divide. Results are bit-identical in both builds.

## Test plan
- MULT `src_a=32'hFFFFFFFD` (-3), `src_b=5` → `hi_o=32'hFFFFFFFF`, `lo_o=32'hFFFFFFF1`, `write_en` for exactly one cycle (cycle 1 fast, cycle 33 iterative).
- MULTU `32'hFFFFFFFF × 32'hFFFFFFFF` → `hi_o=32'hFFFFFFFE`, `lo_o=32'h00000001`.
- DIV `-7 / 2` → `lo_o=32'hFFFFFFFD`, `hi_o=32'hFFFFFFFF`; `busy=1` cycles 0–32, `write_en=1` in cycle 33 only.
- DIVU `src_a=32'h12345678`, `src_b=0` → cycle 1: `write_en=1`, `hi_o=32'h12345678`, `lo_o=32'hFFFFFFFF`.
- DIVU `100/7` with `flush` in cycle 10:
  - `busy=0` from cycle 11; no `write_en`; `hi_o`/`lo_o` keep their prior values.
  - A new DIVU `100/7` started in cycle 11 gives `lo_o=14`, `hi_o=2` in cycle 44.
- `rst` pulsed in cycle 20 of a DIV → all outputs 0 immediately; no `write_en` after release; the next operation completes normally.
